meep_rst_sequencer: RTL and testbench
=====================================

// Module: meep_rst_sequencer
// PURPOSE
//  Parametrised reset/bring-up sequencer for the MEEP shell, driving NUM_DOM active-low domain resets.
//  Gates on NUM_CALIB memory-calibration flags and a host soft-reset bit on pcie_gpio.
//  Releases domains in a staggered order, re-enters reset on soft reset or calibration loss, and
//  flags calibration timeout. Sits in the chipset_clk domain between the shell and the tile/chipset resets.
// PARAMETERS
//  NUM_DOM        4        number of reset domains; index 0 released first
//  NUM_CALIB      2        number of calibration-done inputs
//  GPIO_W         5        pcie_gpio width
//  RST_GPIO_BIT   0        pcie_gpio bit used as host soft-reset request (level, active-high)
//  BYP_GPIO_BIT   1        pcie_gpio bit that bypasses the calibration wait when high
//  MIN_ASSERT     32       minimum cycles all domains are held in HOLD (>=1)
//  STAGE_DLY      16       cycles between consecutive domain releases (>=1)
//  CAL_TIMEOUT    1048576  max cycles in WAIT_CAL before FAIL
// PORTS
//  chipset_clk    in   1          single clock
//  chipset_rst    in   1          synchronous, active-high reset
//  pcie_gpio      in   GPIO_W     host GPIO; asynchronous, synchronised internally
//  calib_done     in   NUM_CALIB  per-controller calibration complete; asynchronous
//  dom_rstn       out  NUM_DOM    per-domain reset, active-low, registered
//  seq_busy       out  1          high in HOLD/WAIT_CAL/RELEASE
//  seq_done       out  1          high in RUN only
//  cal_timeout    out  1          sticky; set on WAIT_CAL timeout, cleared only by chipset_rst
//  soft_rst_cnt   out  8          saturating count of soft-reset and calibration-loss re-entries
// BEHAVIOUR
//  - Reset values: state=HOLD, dom_rstn=0, seq_busy=1, seq_done=0, cal_timeout=0, soft_rst_cnt=0.
//  - Synchronisation: pcie_gpio and calib_done pass through 2-flop synchronisers (2-cycle latency).
//    All decisions use the synced values.
//    cal_ok = &calib_done_s | gpio_s[BYP_GPIO_BIT].
//    soft_req = rising edge of gpio_s[RST_GPIO_BIT].
//  - One cycle counter cnt (width sized to max(MIN_ASSERT,STAGE_DLY,CAL_TIMEOUT)); zeroed on every state entry.
//  - HOLD: dom_rstn=0. Counts while gpio_s[RST_GPIO_BIT]=0; the counter is held at 0 while the bit is high.
//    Goes to WAIT_CAL on the cycle cnt==MIN_ASSERT-1 and bit low.
//  - WAIT_CAL: goes to RELEASE on the first cycle cal_ok=1.
//    If cnt==CAL_TIMEOUT-1 with cal_ok=0: set cal_timeout, go to FAIL.
//  - RELEASE: idx starts at 0. When cnt==STAGE_DLY-1: dom_rstn[idx]<=1, idx++, cnt<=0.
//    dom_rstn[i] rises exactly (i+1)*STAGE_DLY cycles after RELEASE entry.
//    Goes to RUN on the cycle the last domain releases. If cal_ok drops: go to HOLD.
//  - RUN: all dom_rstn=1, seq_done=1. If cal_ok falls to 0: go to HOLD and increment soft_rst_cnt.
//  - FAIL: dom_rstn=0, seq_busy=0, seq_done=0. Exits only via soft_req (to HOLD) or chipset_rst.
//  - soft_req in any state (including HOLD): go to HOLD, cnt<=0, increment soft_rst_cnt (saturates at 255).
//    soft_req takes priority over all other transitions in the same cycle.
//  - Entering HOLD drives all dom_rstn to 0 on the next clock edge, regardless of release progress.
//  - chipset_rst mid-sequence: immediate return to reset values; synchronisers cleared to 0.
//  - Outputs are registered, with no combinational input-to-output path.
// TESTING
//  (bench params MIN_ASSERT=8, STAGE_DLY=4, CAL_TIMEOUT=100, NUM_DOM=4)
//  1. calib_done=2'b11 before reset release.
//     -> dom_rstn goes 0001,0011,0111,1111 at 4-cycle spacing; seq_done=1; soft_rst_cnt=0.
//  2. calib_done=0, bypass=0.
//     -> cal_timeout=1 after 100 cycles in WAIT_CAL; state FAIL; dom_rstn=0.
//     -> A gpio[0] pulse then returns the block to HOLD with cal_timeout still 1.
//  3. In RUN, pulse gpio[0] high 3 cycles.
//     -> dom_rstn=0 within 4 cycles; HOLD extended while the bit is high; full re-sequence; soft_rst_cnt=1.
//  4. In RELEASE after dom_rstn=0011, drop calib_done[1].
//     -> HOLD, all dom_rstn=0; re-sequence once calib returns.
//  5. gpio[1]=1 with calib_done=0.
//     -> sequence completes as in test 1; cal_timeout stays 0.
//  6. 300 soft-reset pulses -> soft_rst_cnt saturates at 255.
//     chipset_rst asserted mid-RELEASE -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/meep_rst_sequencer_if.sv
// Signal bundle between the MEEP shell host side and the reset/bring-up sequencer.
interface meep_rst_sequencer_if #(
    parameter int unsigned NUM_DOM   = 4,
    parameter int unsigned NUM_CALIB = 2,
    parameter int unsigned GPIO_W    = 5
);
    logic [GPIO_W-1:0]    pcie_gpio;
    logic [NUM_CALIB-1:0] calib_done;
    logic [NUM_DOM-1:0]   dom_rstn;
    logic                 seq_busy;
    logic                 seq_done;
    logic                 cal_timeout;
    logic [7:0]           soft_rst_cnt;

    modport master (
        output pcie_gpio,
        output calib_done,
        input  dom_rstn,
        input  seq_busy,
        input  seq_done,
        input  cal_timeout,
        input  soft_rst_cnt
    );

    modport slave (
        input  pcie_gpio,
        input  calib_done,
        output dom_rstn,
        output seq_busy,
        output seq_done,
        output cal_timeout,
        output soft_rst_cnt
    );
endinterface

// File: rtl/meep_rst_sequencer.sv
// Reset/bring-up sequencer: holds domains in reset, waits for memory calibration, then
// releases the domain resets in a staggered order and supervises soft-reset/calibration loss.
module meep_rst_sequencer #(
    parameter int unsigned NUM_DOM      = 4,
    parameter int unsigned NUM_CALIB    = 2,
    parameter int unsigned GPIO_W       = 5,
    parameter int unsigned RST_GPIO_BIT = 0,
    parameter int unsigned BYP_GPIO_BIT = 1,
    parameter int unsigned MIN_ASSERT   = 32,
    parameter int unsigned STAGE_DLY    = 16,
    parameter int unsigned CAL_TIMEOUT  = 1048576
) (
    input  logic                 chipset_clk,
    input  logic                 chipset_rst,
    meep_rst_sequencer_if.slave  bus
);

    localparam int unsigned MaxDly0 = (MIN_ASSERT > STAGE_DLY) ? MIN_ASSERT : STAGE_DLY;
    localparam int unsigned MaxDly  = (CAL_TIMEOUT > MaxDly0) ? CAL_TIMEOUT : MaxDly0;
    localparam int unsigned CntW    = (MaxDly > 1) ? $clog2(MaxDly) : 1;
    localparam int unsigned IdxW    = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

    localparam logic [CntW-1:0] HoldLast  = CntW'(MIN_ASSERT - 1);
    localparam logic [CntW-1:0] StageLast = CntW'(STAGE_DLY - 1);
    localparam logic [CntW-1:0] CalLast   = CntW'(CAL_TIMEOUT - 1);
    localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_DOM - 1);

    typedef enum logic [2:0] {
        StHold,
        StWaitCal,
        StRelease,
        StRun,
        StFail
    } state_e;

    // Input synchronisers
    logic [GPIO_W-1:0]    gpio_meta, gpio_s;
    logic [NUM_CALIB-1:0] calib_meta, calib_s;
    logic                 rst_bit_q;

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            gpio_meta  <= '0;
            gpio_s     <= '0;
            calib_meta <= '0;
            calib_s    <= '0;
            rst_bit_q  <= 1'b0;
        end else begin
            gpio_meta  <= bus.pcie_gpio;
            gpio_s     <= gpio_meta;
            calib_meta <= bus.calib_done;
            calib_s    <= calib_meta;
            rst_bit_q  <= gpio_s[RST_GPIO_BIT];
        end
    end

    logic cal_ok;
    logic soft_req;
    logic unused_gpio_bits;

    assign cal_ok           = (&calib_s) | gpio_s[BYP_GPIO_BIT];
    assign soft_req         = gpio_s[RST_GPIO_BIT] & ~rst_bit_q;
    assign unused_gpio_bits = ^gpio_s;

    // Sequencer state
    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [NUM_DOM-1:0]  dom_rstn_q, dom_rstn_d;
    logic                seq_busy_q, seq_busy_d;
    logic                seq_done_q, seq_done_d;
    logic                cal_timeout_q, cal_timeout_d;
    logic [7:0]          soft_cnt_q, soft_cnt_d;
    logic                bump;

    always_comb begin
        state_d       = state_q;
        cnt_d         = '0;
        idx_d         = idx_q;
        dom_rstn_d    = dom_rstn_q;
        cal_timeout_d = cal_timeout_q;
        bump          = 1'b0;

        unique case (state_q)
            StHold: begin
                dom_rstn_d = '0;
                idx_d      = '0;
                // Minimum-assert window only advances while the host keeps soft reset low
                if (!gpio_s[RST_GPIO_BIT]) begin
                    if (cnt_q == HoldLast) begin
                        state_d = StWaitCal;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StWaitCal: begin
                if (cal_ok) begin
                    state_d = StRelease;
                    idx_d   = '0;
                end else if (cnt_q == CalLast) begin
                    state_d       = StFail;
                    cal_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelease: begin
                if (!cal_ok) begin
                    state_d    = StHold;
                    dom_rstn_d = '0;
                end else if (cnt_q == StageLast) begin
                    dom_rstn_d = dom_rstn_q | (NUM_DOM'(1) << idx_q);
                    idx_d      = idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        state_d = StRun;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                dom_rstn_d = '1;
                if (!cal_ok) begin
                    state_d    = StHold;
                    dom_rstn_d = '0;
                    bump       = 1'b1;
                end
            end
            StFail: begin
                dom_rstn_d = '0;
            end
            default: begin
                state_d    = StHold;
                dom_rstn_d = '0;
            end
        endcase

        // Host soft reset overrides whatever the state logic decided this cycle
        if (soft_req) begin
            state_d    = StHold;
            cnt_d      = '0;
            idx_d      = '0;
            dom_rstn_d = '0;
            bump       = 1'b1;
        end
    end

    always_comb begin
        soft_cnt_d = soft_cnt_q;
        if (bump && (soft_cnt_q != 8'hFF)) begin
            soft_cnt_d = soft_cnt_q + 8'd1;
        end
        seq_busy_d = (state_d == StHold) || (state_d == StWaitCal) || (state_d == StRelease);
        seq_done_d = (state_d == StRun);
    end

    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            state_q       <= StHold;
            cnt_q         <= '0;
            idx_q         <= '0;
            dom_rstn_q    <= '0;
            seq_busy_q    <= 1'b1;
            seq_done_q    <= 1'b0;
            cal_timeout_q <= 1'b0;
            soft_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            dom_rstn_q    <= dom_rstn_d;
            seq_busy_q    <= seq_busy_d;
            seq_done_q    <= seq_done_d;
            cal_timeout_q <= cal_timeout_d;
            soft_cnt_q    <= soft_cnt_d;
        end
    end

    assign bus.dom_rstn     = dom_rstn_q;
    assign bus.seq_busy     = seq_busy_q;
    assign bus.seq_done     = seq_done_q;
    assign bus.cal_timeout  = cal_timeout_q;
    assign bus.soft_rst_cnt = soft_cnt_q;

endmodule

// File: tb/tb_meep_rst_sequencer.sv
// Bench for meep_rst_sequencer: directed bring-up scenarios plus random stimulus, every cycle
// compared against a phase/elapsed-time reference model.
module tb_meep_rst_sequencer;

    localparam int unsigned NUM_DOM     = 4;
    localparam int unsigned NUM_CALIB   = 2;
    localparam int unsigned GPIO_W      = 5;
    localparam int unsigned MIN_ASSERT  = 8;
    localparam int unsigned STAGE_DLY   = 4;
    localparam int unsigned CAL_TIMEOUT = 100;

    localparam int PH_HOLD = 0, PH_WAIT = 1, PH_REL = 2, PH_RUN = 3, PH_FAIL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    meep_rst_sequencer_if #(
        .NUM_DOM   (NUM_DOM),
        .NUM_CALIB (NUM_CALIB),
        .GPIO_W    (GPIO_W)
    ) bus ();

    meep_rst_sequencer #(
        .NUM_DOM      (NUM_DOM),
        .NUM_CALIB    (NUM_CALIB),
        .GPIO_W       (GPIO_W),
        .RST_GPIO_BIT (0),
        .BYP_GPIO_BIT (1),
        .MIN_ASSERT   (MIN_ASSERT),
        .STAGE_DLY    (STAGE_DLY),
        .CAL_TIMEOUT  (CAL_TIMEOUT)
    ) dut (
        .chipset_clk (clk),
        .chipset_rst (rst),
        .bus         (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference model: phase plus cycles elapsed in it, synchronisers as plain delay taps
    int         m_phase = PH_HOLD;
    int         m_t     = 0;
    logic [3:0] m_dom   = '0;
    logic       m_to    = 1'b0;
    int         m_cnt   = 0;
    logic [4:0] m_g1 = '0, m_g2 = '0;
    logic [1:0] m_c1 = '0, m_c2 = '0;
    logic       m_prev = 1'b0;

    task automatic model_edge(input logic r, input logic [4:0] g, input logic [1:0] c);
        logic req, ok;
        int   nt;
        if (r) begin
            m_phase = PH_HOLD; m_t = 0; m_dom = '0; m_to = 1'b0; m_cnt = 0;
            m_g1 = '0; m_g2 = '0; m_c1 = '0; m_c2 = '0; m_prev = 1'b0;
        end else begin
            req = m_g2[0] && !m_prev;
            ok  = (&m_c2) || m_g2[1];
            nt  = m_t + 1;
            if (req) begin
                m_phase = PH_HOLD;
                nt      = 0;
                if (m_cnt < 255) m_cnt++;
            end else begin
                case (m_phase)
                    PH_HOLD: begin
                        if (m_g2[0]) nt = 0;
                        else if (nt == MIN_ASSERT) begin m_phase = PH_WAIT; nt = 0; end
                    end
                    PH_WAIT: begin
                        if (ok) begin m_phase = PH_REL; nt = 0; end
                        else if (nt == CAL_TIMEOUT) begin m_phase = PH_FAIL; m_to = 1'b1; nt = 0; end
                    end
                    PH_REL: begin
                        if (!ok) begin m_phase = PH_HOLD; nt = 0; end
                        else if (nt / STAGE_DLY == NUM_DOM) m_phase = PH_RUN;
                    end
                    PH_RUN: begin
                        if (!ok) begin
                            m_phase = PH_HOLD; nt = 0;
                            if (m_cnt < 255) m_cnt++;
                        end
                    end
                    default: nt = 0;
                endcase
            end
            m_t = nt;
            case (m_phase)
                PH_REL:  m_dom = 4'((1 << (nt / STAGE_DLY)) - 1);
                PH_RUN:  m_dom = 4'hF;
                default: m_dom = 4'h0;
            endcase
            m_prev = m_g2[0]; m_g2 = m_g1; m_g1 = g; m_c2 = m_c1; m_c1 = c;
        end
    endtask

    function automatic logic [14:0] dut_outs();
        return {bus.dom_rstn, bus.seq_busy, bus.seq_done, bus.cal_timeout, bus.soft_rst_cnt};
    endfunction

    function automatic logic [14:0] model_outs();
        return {m_dom, (m_phase <= PH_REL), (m_phase == PH_RUN), m_to, 8'(m_cnt)};
    endfunction

    task automatic step();
        model_edge(rst, bus.pcie_gpio, bus.calib_done);
        @(posedge clk);
        #1;
        cyc++;
        check_eq("outputs", 64'(dut_outs()), 64'(model_outs()));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_phase(input int ph, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_phase == ph) break;
            step();
        end
    endtask

    task automatic do_reset(input logic [4:0] g, input logic [1:0] c);
        bus.pcie_gpio  = g;
        bus.calib_done = c;
        rst = 1'b1;
        run(2);
        rst = 1'b0;
    endtask

    int         rise_t [4];
    logic [3:0] prev_dom;
    logic [3:0] seen [$];

    initial begin
        rst = 1'b1;
        bus.pcie_gpio  = '0;
        bus.calib_done = 2'b11;
        run(3);
        check_eq("reset_state", 64'(dut_outs()), 64'({4'h0, 1'b1, 1'b0, 1'b0, 8'h00}));

        // 1: calibration ready before reset release
        rst = 1'b0;
        prev_dom = '0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (bus.dom_rstn != prev_dom) begin
                seen.push_back(bus.dom_rstn);
                for (int b = 0; b < 4; b++)
                    if (bus.dom_rstn[b] && !prev_dom[b]) rise_t[b] = cyc;
                prev_dom = bus.dom_rstn;
            end
            if (bus.seq_done) break;
        end
        check_eq("t1_steps", 64'(seen.size()), 64'd4);
        if (seen.size() == 4) begin
            check_eq("t1_pat0", 64'(seen[0]), 64'h1);
            check_eq("t1_pat1", 64'(seen[1]), 64'h3);
            check_eq("t1_pat2", 64'(seen[2]), 64'h7);
            check_eq("t1_pat3", 64'(seen[3]), 64'hF);
            for (int b = 1; b < 4; b++)
                check_eq("t1_gap", 64'(rise_t[b] - rise_t[b-1]), 64'(STAGE_DLY));
        end
        check_eq("t1_done", 64'(bus.seq_done), 64'd1);
        check_eq("t1_softcnt", 64'(bus.soft_rst_cnt), 64'd0);

        // 2: calibration never arrives
        do_reset(5'b00000, 2'b00);
        wait_phase(PH_FAIL, 300);
        step();
        check_eq("t2_timeout", 64'(bus.cal_timeout), 64'd1);
        check_eq("t2_dom", 64'(bus.dom_rstn), 64'd0);
        check_eq("t2_busy", 64'(bus.seq_busy), 64'd0);
        bus.pcie_gpio = 5'b00001;
        run(2);
        bus.pcie_gpio = 5'b00000;
        run(3);
        check_eq("t2_hold_busy", 64'(bus.seq_busy), 64'd1);
        check_eq("t2_sticky", 64'(bus.cal_timeout), 64'd1);
        check_eq("t2_softcnt", 64'(bus.soft_rst_cnt), 64'd1);

        // 3: soft reset pulse while running
        do_reset(5'b00000, 2'b11);
        wait_phase(PH_RUN, 200);
        step();
        bus.pcie_gpio = 5'b00001;
        run(3);
        bus.pcie_gpio = 5'b00000;
        step();
        check_eq("t3_dom_low", 64'(bus.dom_rstn), 64'd0);
        wait_phase(PH_RUN, 200);
        step();
        check_eq("t3_dom_full", 64'(bus.dom_rstn), 64'hF);
        check_eq("t3_softcnt", 64'(bus.soft_rst_cnt), 64'd1);

        // 4: calibration loss mid-release
        do_reset(5'b00000, 2'b11);
        for (int i = 0; i < 200; i++) begin
            if (m_dom == 4'h3) break;
            step();
        end
        check_eq("t4_partial", 64'(bus.dom_rstn), 64'h3);
        bus.calib_done = 2'b01;
        run(3);
        check_eq("t4_dom_low", 64'(bus.dom_rstn), 64'd0);
        bus.calib_done = 2'b11;
        wait_phase(PH_RUN, 200);
        step();
        check_eq("t4_resequenced", 64'(bus.dom_rstn), 64'hF);

        // 5: bypass with no calibration
        do_reset(5'b00010, 2'b00);
        wait_phase(PH_RUN, 200);
        step();
        check_eq("t5_dom", 64'(bus.dom_rstn), 64'hF);
        check_eq("t5_timeout", 64'(bus.cal_timeout), 64'd0);

        // 6: counter saturation, then reset mid-release
        do_reset(5'b00000, 2'b11);
        for (int i = 0; i < 300; i++) begin
            bus.pcie_gpio = 5'b00001;
            step();
            bus.pcie_gpio = 5'b00000;
            step();
        end
        run(3);
        check_eq("t6_saturate", 64'(bus.soft_rst_cnt), 64'd255);
        for (int i = 0; i < 200; i++) begin
            if (m_dom == 4'h1) break;
            step();
        end
        rst = 1'b1;
        step();
        check_eq("t6_midrst", 64'(dut_outs()), 64'({4'h0, 1'b1, 1'b0, 1'b0, 8'h00}));
        rst = 1'b0;

        // Random stimulus against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) bus.pcie_gpio[0] = ~bus.pcie_gpio[0];
            if ($urandom_range(0, 199) < 2) bus.pcie_gpio[1] = ~bus.pcie_gpio[1];
            if ($urandom_range(0, 99) < 3) bus.calib_done = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) < 5) bus.pcie_gpio[4:2] = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 999) < 3);
            step();
        end
        rst = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
